// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry (drain, CSR save, flush, redirect) and MRET sequencing.
// Optional taken-interrupt counter on irq_count_o when TRAP_STATS_EN is defined.
module trap_sequencer #(
    parameter int         DRAIN_TIMEOUT = 64,
    parameter logic [1:0] MPP_VAL       = 2'b11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        interrupt_valid_i,
    input  logic [31:0] handler_addr_i,
    input  logic [31:0] ecause_i,
    input  logic [31:0] epc_i,
    input  logic        pipe_busy_i,
    input  logic        mret_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mstatus_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        csr_we_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mstatus_o,
    output logic        irq_ack_o,
    output logic        drain_timeout_o,
    output logic [31:0] irq_count_o
);
    typedef enum logic [2:0] {IDLE, DRAIN, SAVE, REDIR, MRET} state_t;
    localparam int CW = $clog2(DRAIN_TIMEOUT + 2);
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    epc_q, epc_d, cause_q, cause_d, handler_q, handler_d;
    logic           to_q, to_d, timeout;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            handler_q <= '0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            handler_q <= handler_d;
            to_q      <= to_d;
        end
    end

    always_comb begin
        timeout   = (DRAIN_TIMEOUT != 0) && (cnt_q == CW'(DRAIN_TIMEOUT - 1));
        state_d   = state_q;
        cnt_d     = '0;
        epc_d     = epc_q;
        cause_d   = cause_q;
        handler_d = handler_q;
        to_d      = to_q;
        case (state_q)
            IDLE: state_d = interrupt_valid_i ? DRAIN : mret_i ? MRET : IDLE;
            DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                // a timeout counts as drained, but an abort still wins while busy
                if (!pipe_busy_i || (interrupt_valid_i && timeout)) begin
                    state_d   = SAVE;
                    cnt_d     = '0;
                    epc_d     = epc_i;
                    cause_d   = ecause_i;
                    handler_d = handler_addr_i & 32'hFFFF_FFFC;
                    to_d      = to_q | pipe_busy_i;
                end else if (!interrupt_valid_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            SAVE:    state_d = REDIR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o         = rst_i & ((state_q != IDLE) | interrupt_valid_i);
        csr_we_o        = (state_q == SAVE) || (state_q == MRET);
        flush_o         = (state_q == REDIR) || (state_q == MRET);
        redirect_o      = flush_o;
        irq_ack_o       = state_q == REDIR;
        redirect_pc_o   = (state_q == MRET) ? (mepc_i & 32'hFFFF_FFFC) : handler_q;
        mepc_o          = epc_q & 32'hFFFF_FFFC;
        mcause_o        = cause_q;
        drain_timeout_o = to_q;
        mstatus_o       = '0;
        if (state_q == SAVE) begin
            mstatus_o        = mstatus_i;
            mstatus_o[7]     = mstatus_i[3];
            mstatus_o[3]     = 1'b0;
            mstatus_o[12:11] = MPP_VAL;
        end else if (state_q == MRET) begin
            mstatus_o        = mstatus_i;
            mstatus_o[3]     = mstatus_i[7];
            mstatus_o[7]     = 1'b1;
            mstatus_o[12:11] = 2'b00;
        end
    end

`ifdef TRAP_STATS_EN
    logic [31:0] irq_cnt_q, irq_cnt_d;
    always_comb irq_cnt_d = (irq_ack_o && irq_cnt_q != '1) ? irq_cnt_q + 32'd1 : irq_cnt_q;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) irq_cnt_q <= '0;
        else        irq_cnt_q <= irq_cnt_d;
    end
    assign irq_count_o = irq_cnt_q;
`else
    assign irq_count_o = '0;
`endif
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed checks of trap entry, drain wait, timeout, abort, MRET and reset.
module tb_trap_sequencer;
    logic        clk_i = 1'b0, rst_i = 1'b0;
    logic        interrupt_valid_i = 0, pipe_busy_i = 0, mret_i = 0;
    logic [31:0] handler_addr_i = 0, ecause_i = 0, epc_i = 0, mepc_i = 0, mstatus_i = 0;
    logic        stall_o, flush_o, redirect_o, csr_we_o, irq_ack_o, drain_timeout_o;
    logic [31:0] redirect_pc_o, mepc_o, mcause_o, mstatus_o, irq_count_o;
    int          checks = 0, errors = 0;

    trap_sequencer #(.DRAIN_TIMEOUT(8), .MPP_VAL(2'b11)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .interrupt_valid_i(interrupt_valid_i),
        .handler_addr_i(handler_addr_i), .ecause_i(ecause_i), .epc_i(epc_i),
        .pipe_busy_i(pipe_busy_i), .mret_i(mret_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i),
        .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .csr_we_o(csr_we_o), .mepc_o(mepc_o),
        .mcause_o(mcause_o), .mstatus_o(mstatus_o), .irq_ack_o(irq_ack_o),
        .drain_timeout_o(drain_timeout_o), .irq_count_o(irq_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #2;
        check("rst_stall", 32'(stall_o), 0);
        check("rst_csr_we", 32'(csr_we_o), 0);
        check("rst_redirect_pc", redirect_pc_o, 0);
        check("rst_mstatus", mstatus_o, 0);
        check("rst_timeout", 32'(drain_timeout_o), 0);
        check("rst_irq_count", irq_count_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // basic entry
        interrupt_valid_i = 1; epc_i = 32'h100; ecause_i = 32'h8000000B;
        handler_addr_i = 32'h2F; mstatus_i = 32'h8;
        #1;
        check("req_stall", 32'(stall_o), 1);
        check("req_ack", 32'(irq_ack_o), 0);
        tick();
        check("drain_stall", 32'(stall_o), 1);
        check("drain_we", 32'(csr_we_o), 0);
        tick();
        epc_i = 32'h204;
        #1;
        check("save_we", 32'(csr_we_o), 1);
        check("save_mepc", mepc_o, 32'h100);
        check("save_mcause", mcause_o, 32'h8000000B);
        check("save_mstatus", mstatus_o, 32'h1880);
        check("save_redirect", 32'(redirect_o), 0);
        check("save_stall", 32'(stall_o), 1);
        tick();
        check("redir_valid", 32'(redirect_o), 1);
        check("redir_pc", redirect_pc_o, 32'h2C);
        check("redir_flush", 32'(flush_o), 1);
        check("redir_ack", 32'(irq_ack_o), 1);
        check("redir_we", 32'(csr_we_o), 0);
        interrupt_valid_i = 0;
        tick();
        check("idle_stall", 32'(stall_o), 0);
        check("idle_redirect", 32'(redirect_o), 0);
        check("idle_ack", 32'(irq_ack_o), 0);

        // drain wait: busy for 5 drain cycles
        interrupt_valid_i = 1; pipe_busy_i = 1; epc_i = 32'h200; ecause_i = 32'h80000007;
        handler_addr_i = 32'h40; mstatus_i = 32'h0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wait_stall%0d", i), 32'(stall_o), 1);
            check($sformatf("wait_we%0d", i), 32'(csr_we_o), 0);
            tick();
        end
        pipe_busy_i = 0;
        #1;
        check("wait_last_we", 32'(csr_we_o), 0);
        tick();
        check("wait_save_we", 32'(csr_we_o), 1);
        check("wait_mepc", mepc_o, 32'h200);
        check("wait_mcause", mcause_o, 32'h80000007);
        check("wait_mstatus", mstatus_o, 32'h1800);
        check("wait_timeout", 32'(drain_timeout_o), 0);
        tick();
        check("wait_redir_pc", redirect_pc_o, 32'h40);
        check("wait_ack", 32'(irq_ack_o), 1);
        interrupt_valid_i = 0;
        tick();

        // timeout after 8 drain cycles
        interrupt_valid_i = 1; pipe_busy_i = 1; epc_i = 32'h302; ecause_i = 32'h3;
        handler_addr_i = 32'h80; mstatus_i = 32'h88;
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to_we%0d", i), 32'(csr_we_o), 0);
            check($sformatf("to_flag%0d", i), 32'(drain_timeout_o), 0);
            tick();
        end
        check("to_save_we", 32'(csr_we_o), 1);
        check("to_mepc", mepc_o, 32'h300);
        check("to_mstatus", mstatus_o, 32'h1880);
        check("to_flag", 32'(drain_timeout_o), 1);
        tick();
        check("to_redir_pc", redirect_pc_o, 32'h80);
        interrupt_valid_i = 0; pipe_busy_i = 0;
        tick();
        check("to_sticky", 32'(drain_timeout_o), 1);

        // abort in drain
        interrupt_valid_i = 1; pipe_busy_i = 1;
        tick();
        tick();
        interrupt_valid_i = 0;
        #1;
        check("abort_drain_stall", 32'(stall_o), 1);
        tick();
        check("abort_stall", 32'(stall_o), 0);
        check("abort_we", 32'(csr_we_o), 0);
        check("abort_redirect", 32'(redirect_o), 0);
        tick();
        check("abort_redirect2", 32'(redirect_o), 0);
        pipe_busy_i = 0;

        // MRET
        mret_i = 1; mepc_i = 32'h103; mstatus_i = 32'h1880;
        #1;
        check("mret_req_stall", 32'(stall_o), 0);
        tick();
        mret_i = 0;
        #1;
        check("mret_redirect", 32'(redirect_o), 1);
        check("mret_pc", redirect_pc_o, 32'h100);
        check("mret_mstatus", mstatus_o, 32'h88);
        check("mret_we", 32'(csr_we_o), 1);
        check("mret_flush", 32'(flush_o), 1);
        check("mret_ack", 32'(irq_ack_o), 0);
        check("mret_mepc_hold", mepc_o, 32'h300);
        check("mret_stall", 32'(stall_o), 1);
        tick();
        check("mret_done", 32'(redirect_o), 0);

        // simultaneous MRET and interrupt: interrupt wins
        mret_i = 1; interrupt_valid_i = 1; epc_i = 32'h400; ecause_i = 32'hB;
        handler_addr_i = 32'h100; mstatus_i = 32'h8;
        tick();
        mret_i = 0;
        #1;
        check("both_redirect", 32'(redirect_o), 0);
        check("both_we", 32'(csr_we_o), 0);
        tick();
        check("both_save_mepc", mepc_o, 32'h400);
        tick();
        check("both_redir_pc", redirect_pc_o, 32'h100);
        check("both_ack", 32'(irq_ack_o), 1);
        interrupt_valid_i = 0;
        tick();
`ifdef TRAP_STATS_EN
        check("irq_count", irq_count_o, 4);
`else
        check("irq_count", irq_count_o, 0);
`endif

        // reset mid-SAVE
        interrupt_valid_i = 1; epc_i = 32'h500;
        tick();
        tick();
        check("rs_save_we", 32'(csr_we_o), 1);
        interrupt_valid_i = 0;
        #2;
        rst_i = 1'b0;
        #1;
        check("rs_we", 32'(csr_we_o), 0);
        check("rs_stall", 32'(stall_o), 0);
        check("rs_mepc", mepc_o, 0);
        check("rs_mcause", mcause_o, 0);
        check("rs_timeout", 32'(drain_timeout_o), 0);
        check("rs_irq_count", irq_count_o, 0);
        check("rs_redirect_pc", redirect_pc_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        check("post_rs_stall", 32'(stall_o), 0);
        check("post_rs_we", 32'(csr_we_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
